life_sequencer: RTL and testbench

- Control state machine for life_engine, clocked on clk4 (192 MHz).
- Drives the engine's raddr/waddr/we/re/ld/init strobes to:
  - sweep-load an initial pattern;
  - compute whole generations in place;
  - steal single read slots so the video path can latch display rows into dout.
- Counts completed generations for the on-screen generation counter.

---
 rtl/life_sequencer.sv | 175 +++++++++++++++++
 tb/tb_life_sequencer.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// life_sequencer: control FSM for life_engine (clk4 domain).
// Init sweep, in-place generations and stolen display read slots.
module life_sequencer #(
  parameter int ROWS  = 256,
  parameter int RBITS = 8,
  parameter int CNTW  = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             init_req,
  input  logic             disp_req,
  input  logic [RBITS-1:0] disp_row,
  output logic             disp_ack,
  output logic [RBITS-1:0] raddr,
  output logic [RBITS-1:0] waddr,
  output logic             re,
  output logic             we,
  output logic             ld,
  output logic             init,
  output logic             busy,
  output logic             gen_done,
  output logic [CNTW-1:0]  gen_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_GEN
  } state_t;

  localparam logic [RBITS-1:0] LAST = RBITS'(ROWS - 1);
  localparam logic [RBITS-1:0] TWO  = RBITS'(2);

  state_t           state_q, state_d;
  logic [RBITS-1:0] row_q, row_d;
  logic [1:0]       ph_q, ph_d;
  logic             lat_q, lat_d;
  logic             pend_q, pend_d;
  logic             last_q, last_d;
  logic             serve;

  logic [RBITS-1:0] raddr_d, waddr_d;
  logic             re_d, we_d, ld_d, init_d;
  logic             ack_d, busy_d, done_d;
  logic [CNTW-1:0]  cnt_d;

  // next state, row/phase sequencing and next output values
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ph_d    = ph_q;
    lat_d   = lat_q;
    pend_d  = 1'b0;
    last_d  = 1'b0;
    raddr_d = '0;
    waddr_d = '0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    init_d  = 1'b0;
    ld_d    = pend_q;
    ack_d   = pend_q;
    busy_d  = (state_q != S_IDLE);
    done_d  = last_q;
    cnt_d   = last_q ? gen_count + CNTW'(1)
                     : gen_count;
    serve   = disp_req & ~pend_q;
    case (state_q)
      S_IDLE: begin
        row_d = '0;
        ph_d  = 2'd0;
        if (serve) begin
          raddr_d = disp_row;
          pend_d  = 1'b1;
        end
        if (init_req || lat_q) begin
          state_d = S_INIT;
          lat_d   = 1'b0;
        end else if (run || step) begin
          state_d = S_GEN;
        end
      end
      S_INIT: begin
        init_d  = 1'b1;
        we_d    = 1'b1;
        waddr_d = row_q;
        row_d   = row_q + 1'b1;
        if (init_req) lat_d = 1'b1;
        if (row_q == LAST) begin
          row_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_GEN: begin
        ph_d = ph_q + 2'd1;
        if (init_req) lat_d = 1'b1;
        unique case (1'b1)
          ph_q == 2'd0: begin
            re_d    = 1'b1;
            raddr_d = row_q;
          end
          ph_q == 2'd1: begin
          end
          ph_q == 2'd2: begin
            if (serve) begin
              raddr_d = disp_row;
              pend_d  = 1'b1;
            end
          end
          ph_q == 2'd3: begin
            if (row_q >= TWO) begin
              we_d    = 1'b1;
              waddr_d = row_q - 1'b1;
            end
            row_d = row_q + 1'b1;
            if (row_q == LAST) begin
              last_d = 1'b1;
              row_d  = '0;
              if (lat_q || init_req) begin
                state_d = S_INIT;
                lat_d   = 1'b0;
              end else if (!run) begin
                state_d = S_IDLE;
              end
            end
          end
          default: begin
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      ph_q      <= '0;
      lat_q     <= 1'b0;
      pend_q    <= 1'b0;
      last_q    <= 1'b0;
      raddr     <= '0;
      waddr     <= '0;
      re        <= 1'b0;
      we        <= 1'b0;
      ld        <= 1'b0;
      init      <= 1'b0;
      disp_ack  <= 1'b0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      gen_count <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      ph_q      <= ph_d;
      lat_q     <= lat_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
      raddr     <= raddr_d;
      waddr     <= waddr_d;
      re        <= re_d;
      we        <= we_d;
      ld        <= ld_d;
      init      <= init_d;
      disp_ack  <= ack_d;
      busy      <= busy_d;
      gen_done  <= done_d;
      gen_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: bench for life_sequencer with an engine model
// and a golden Life model; display reads go through a scoreboard.
module tb_life_sequencer;

  localparam int ROWS  = 256;
  localparam int RBITS = 8;
  localparam int CNTW  = 48;
  localparam int W     = 32;

  logic             clk;
  logic             reset, run, step, init_req, disp_req;
  logic [RBITS-1:0] disp_row;
  logic             disp_ack;
  logic [RBITS-1:0] raddr, waddr;
  logic             re, we, ld, init, busy, gen_done;
  logic [CNTW-1:0]  gen_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int edge_wr = 0;

  logic [W-1:0] emem [ROWS];
  logic [W-1:0] pat  [ROWS];
  logic [W-1:0] gold [ROWS];
  logic [W-1:0] sr0, sr1, sr2, rdq, dout;
  logic [W-1:0] sbq [$];
  logic [RBITS-1:0] wq [$];

  life_sequencer #(.ROWS(ROWS), .RBITS(RBITS), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .init_req(init_req), .disp_req(disp_req),
    .disp_row(disp_row), .disp_ack(disp_ack),
    .raddr(raddr), .waddr(waddr), .re(re), .we(we),
    .ld(ld), .init(init), .busy(busy),
    .gen_done(gen_done), .gen_count(gen_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] life_row(
    input logic [W-1:0] u, input logic [W-1:0] m,
    input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < W; c++) begin
      int n;
      n = 0;
      for (int dc = -1; dc <= 1; dc++) begin
        int cc;
        cc = (c + dc + W) % W;
        n += int'(u[cc]) + int'(d[cc]);
        if (dc != 0) n += int'(m[cc]);
      end
      r[c] = (n == 3) || (m[c] && n == 2);
    end
    return r;
  endfunction

  // engine model: shift-register compute, sync read port, dout latch
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdq <= emem[raddr];
    if (ld) dout <= rdq;
    if (re) begin
      sr2 <= sr1;
      sr1 <= sr0;
      sr0 <= emem[raddr];
    end
    if (we)
      emem[waddr] <= init ? pat[waddr] : life_row(sr2, sr1, sr0);
    if (we && !init && (waddr == 8'd0 || waddr == 8'd255))
      edge_wr <= edge_wr + 1;
  end

  task automatic gold_step();
    logic [W-1:0] t [ROWS];
    t = gold;
    for (int r = 1; r < ROWS - 1; r++)
      gold[r] = life_row(t[r-1], t[r], t[r+1]);
  endtask

  function automatic int mem_diff();
    int d;
    d = 0;
    for (int r = 0; r < ROWS; r++)
      if (emem[r] !== gold[r]) d++;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    init_req = 1'b0; disp_req = 1'b0; disp_row = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({disp_ack, re, we, ld, init, busy, gen_done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0000000",
               {disp_ack, re, we, ld, init, busy, gen_done});
    end
    checks++;
    if (raddr !== '0 || waddr !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%0d/%0d exp=0/0", raddr, waddr);
    end
    checks++;
    if (gen_count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", gen_count);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({re, we, busy} !== 3'b0) begin
      failures++;
      $display("FAIL idle_quiet got=%b exp=000", {re, we, busy});
    end
  endtask

  task automatic test_init();
    int n_init, n_busy, first, last, bad, d;
    logic [RBITS-1:0] e;
    for (int r = 0; r < ROWS; r++) pat[r] = '0;
    pat[100] = 32'h0000_1C00;
    for (int r = 120; r <= 140; r++) pat[r] = $urandom();
    gold = pat;
    wq.delete();
    for (int k = 0; k < ROWS; k++) wq.push_back(RBITS'(k));
    n_init = 0; n_busy = 0; first = -1; last = -1; bad = 0;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (init || we) begin
        n_init++;
        if (first < 0) first = n;
        last = n;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL init_extra got=%0d exp=none", waddr);
        end else begin
          e = wq.pop_front();
          if (waddr !== e || init !== 1'b1 || we !== 1'b1) begin
            failures++;
            $display("FAIL init_waddr got=%0d/%b%b exp=%0d/11",
                     waddr, init, we, e);
          end
        end
      end
      if (busy) n_busy++;
      if (re || ld) bad++;
      @(negedge clk);
    end
    checks++;
    if (n_init != ROWS || last - first + 1 != ROWS) begin
      failures++;
      $display("FAIL init_len got=%0d/%0d exp=256/256",
               n_init, last - first + 1);
    end
    checks++;
    if (n_busy != ROWS) begin
      failures++;
      $display("FAIL init_busy got=%0d exp=256", n_busy);
    end
    checks++;
    if (bad != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL init_side got=%0d/%0d exp=0/0", bad, wq.size());
    end
    d = mem_diff();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL init_mem got=%0d exp=0", d);
    end
  endtask

  task automatic test_step();
    int t_re, t_done, d;
    logic got;
    logic [W-1:0] e;
    t_re = -1; t_done = -1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (re && t_re < 0) t_re = cyc;
      if (gen_done) begin
        t_done = cyc;
        break;
      end
    end
    checks++;
    if (t_done < 0 || t_done - t_re != 1024) begin
      failures++;
      $display("FAIL step_period got=%0d exp=1024", t_done - t_re);
    end
    checks++;
    if (gen_count !== 48'd1) begin
      failures++;
      $display("FAIL step_count got=%0d exp=1", gen_count);
    end
    gold_step();
    d = mem_diff();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL step_mem got=%0d exp=0", d);
    end
    for (int r = 99; r <= 101; r++) begin
      sbq.push_back(32'h0000_0800);
      disp_row = RBITS'(r);
      disp_req = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (disp_ack) begin
          got = 1'b1;
          break;
        end
      end
      disp_req = 1'b0;
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL idle_disp_ack got=0 exp=1 row=%0d", r);
      end
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (dout !== e) begin
        failures++;
        $display("FAIL blinker_row%0d got=%h exp=%h", r, dout, e);
      end
    end
  endtask

  task automatic test_run();
    int t [3];
    int e0, d;
    logic ok;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (gen_count !== '0) begin
      failures++;
      $display("FAIL run_clr got=%0d exp=0", gen_count);
    end
    e0 = edge_wr;
    t = '{0, 0, 0};
    run = 1'b1;
    for (int g = 0; g < 3; g++) begin
      ok = 1'b0;
      for (int n = 0; n < 1100; n++) begin
        @(negedge clk);
        if (gen_done) begin
          t[g] = cyc;
          ok = 1'b1;
          break;
        end
      end
      if (g == 1) run = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL run_timeout got=none exp=gen_done%0d", g);
      end
    end
    checks++;
    if (t[1] - t[0] != 1024 || t[2] - t[1] != 1024) begin
      failures++;
      $display("FAIL run_period got=%0d/%0d exp=1024/1024",
               t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (gen_count !== 48'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_end got=%0d/%b exp=3/0", gen_count, busy);
    end
    checks++;
    if (edge_wr != e0) begin
      failures++;
      $display("FAIL edge_rows got=%0d exp=0", edge_wr - e0);
    end
    gold_step(); gold_step(); gold_step();
    d = mem_diff();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL run_mem got=%0d exp=0", d);
    end
  endtask

  task automatic test_disp_gen();
    logic got, ack_ld, prev_re;
    logic [RBITS-1:0] prev_ra;
    logic [W-1:0] e;
    int lat, extra, d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (re) break;
    end
    repeat (10) @(negedge clk);
    sbq.push_back(gold[128]);
    disp_row = 8'h80;
    disp_req = 1'b1;
    prev_ra = raddr; prev_re = re;
    got = 1'b0; lat = 99; ack_ld = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (disp_ack) begin
        got = 1'b1;
        lat = n - 1;
        ack_ld = ld;
        break;
      end
      prev_ra = raddr;
      prev_re = re;
    end
    disp_req = 1'b0;
    checks++;
    if (!got || lat < 1 || lat > 4) begin
      failures++;
      $display("FAIL gen_disp_lat got=%0d exp=1..4", lat);
    end
    checks++;
    if (ack_ld !== 1'b1) begin
      failures++;
      $display("FAIL gen_disp_ld got=%b exp=1", ack_ld);
    end
    checks++;
    if (prev_ra !== 8'h80 || prev_re !== 1'b0) begin
      failures++;
      $display("FAIL gen_disp_raddr got=%h/%b exp=80/0",
               prev_ra, prev_re);
    end
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (dout !== e) begin
      failures++;
      $display("FAIL gen_disp_dout got=%h exp=%h", dout, e);
    end
    got = 1'b0; extra = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (disp_ack) extra++;
      if (gen_done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || extra != 0 || gen_count !== 48'd4) begin
      failures++;
      $display("FAIL gen_disp_end got=%b/%0d/%0d exp=1/0/4",
               got, extra, gen_count);
    end
    gold_step();
    d = mem_diff();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL gen_disp_mem got=%0d exp=0", d);
    end
  endtask

  task automatic test_init_during_gen();
    logic got;
    int early, n_busy, d;
    for (int r = 0; r < ROWS; r++) pat[r] = $urandom();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (re && raddr == 8'd50) begin
        got = 1'b1;
        break;
      end
    end
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (40) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    early = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (gen_done) begin
        got = got & 1'b1;
        break;
      end
      if (init) early++;
      if (n == 1099) got = 1'b0;
    end
    checks++;
    if (!got || early != 0) begin
      failures++;
      $display("FAIL igen_done got=%b/%0d exp=1/0", got, early);
    end
    checks++;
    if ({init, we} !== 2'b11 || waddr !== 8'd0) begin
      failures++;
      $display("FAIL igen_start got=%b%b/%0d exp=11/0",
               init, we, waddr);
    end
    checks++;
    if (gen_count !== 48'd5) begin
      failures++;
      $display("FAIL igen_count got=%0d exp=5", gen_count);
    end
    n_busy = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
      n_busy++;
    end
    gold = pat;
    d = mem_diff();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL igen_mem got=%0d exp=0", d);
    end
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || re) n_busy++;
    end
    checks++;
    if (n_busy != 0) begin
      failures++;
      $display("FAIL gen_step_ignored got=%0d exp=0", n_busy);
    end
  endtask

  task automatic test_init_step_same();
    int n_re, n_init, n_after;
    init_req = 1'b1;
    step = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    step = 1'b0;
    n_re = 0; n_init = 0; n_after = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (re) n_re++;
      if (init) n_init++;
    end
    repeat (20) begin
      @(negedge clk);
      if (busy || re) n_after++;
    end
    checks++;
    if (n_init != ROWS || n_re != 0 || n_after != 0) begin
      failures++;
      $display("FAIL init_step_same got=%0d/%0d/%0d exp=256/0/0",
               n_init, n_re, n_after);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    int n_we;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (re && raddr == 8'd120) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_mid_row got=none exp=row120");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({disp_ack, re, we, ld, init, busy, gen_done} !== 7'b0 ||
        raddr !== '0 || waddr !== '0 || gen_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_out got=%b/%0d/%0d/%0d exp=0/0/0/0",
               {disp_ack, re, we, ld, init, busy, gen_done},
               raddr, waddr, gen_count);
    end
    reset = 1'b0;
    n_we = 0;
    repeat (60) begin
      @(negedge clk);
      if (we || busy) n_we++;
    end
    checks++;
    if (n_we != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got=%0d exp=0", n_we);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (re) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_mid_restart got=0 exp=1");
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_step();
    test_run();
    test_disp_gen();
    test_init_during_gen();
    test_init_step_same();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
